// File: rtl/lc3b_types.sv
// Shared LC-3b datapath types: a 16-bit word and a 128-bit cache line.
package lc3b_types;

  localparam int WORD_W = 16;
  localparam int LINE_W = 128;

  typedef logic [WORD_W-1:0] lc3b_word;
  typedef logic [LINE_W-1:0] lc3b_line;

endpackage

// File: rtl/cache_arbiter.sv
// Arbitrates one physical memory port between the I-cache and the D-cache.
// The FSM state alone records the current owner. Memory-side signals pass
// combinationally from the owning cache. Read data is broadcast to both caches;
// each cache qualifies that data with its own response signal.
module cache_arbiter
  import lc3b_types::*;
#(
  parameter bit FAIR = 1'b1
) (
  input  logic     clk,
  input  logic     rst_n,

  input  logic     icache_pmem_read,
  input  lc3b_word icache_pmem_address,
  output lc3b_line icache_pmem_rdata,
  output logic     icache_pmem_resp,

  input  logic     dcache_pmem_read,
  input  logic     dcache_pmem_write,
  input  lc3b_word dcache_pmem_address,
  input  lc3b_line dcache_pmem_wdata,
  output lc3b_line dcache_pmem_rdata,
  output logic     dcache_pmem_resp,

  output logic     pmem_read,
  output logic     pmem_write,
  output lc3b_word pmem_address,
  output lc3b_line pmem_wdata,
  input  lc3b_line pmem_rdata,
  input  logic     pmem_resp
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_t;

  typedef enum logic {
    OWNER_I = 1'b0,
    OWNER_D = 1'b1
  } owner_t;

  state_t state, state_next;
  owner_t last_served, last_served_next;

  logic i_req;
  logic d_req;

  assign i_req = icache_pmem_read;
  assign d_req = dcache_pmem_read | dcache_pmem_write;

  // Next-state logic. Every grant passes through IDLE. A grant from IDLE
  // updates last_served. A response or a dropped request returns the FSM to IDLE.
  always_comb begin
    state_next       = state;
    last_served_next = last_served;
    case (state)
      IDLE: begin
        if (i_req && d_req) begin
          // Under round-robin, the side that was not granted last time wins the conflict.
          if (FAIR && (last_served == OWNER_D)) begin
            state_next       = SERVE_I;
            last_served_next = OWNER_I;
          end else begin
            state_next       = SERVE_D;
            last_served_next = OWNER_D;
          end
        end else if (i_req) begin
          state_next       = SERVE_I;
          last_served_next = OWNER_I;
        end else if (d_req) begin
          state_next       = SERVE_D;
          last_served_next = OWNER_D;
        end
      end
      SERVE_I: begin
        if (pmem_resp || !i_req) state_next = IDLE;
      end
      SERVE_D: begin
        if (pmem_resp || !d_req) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State and fairness registers. Reset is asynchronous, so the memory port releases immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      last_served <= OWNER_I;
    end else begin
      state       <= state_next;
      last_served <= last_served_next;
    end
  end

  // Output mux. The owner's signals reach memory. The response goes only to the owner.
  always_comb begin
    pmem_read        = 1'b0;
    pmem_write       = 1'b0;
    pmem_address     = '0;
    pmem_wdata       = '0;
    icache_pmem_resp = 1'b0;
    dcache_pmem_resp = 1'b0;
    case (state)
      SERVE_I: begin
        pmem_read        = icache_pmem_read;
        pmem_address     = icache_pmem_address;
        icache_pmem_resp = pmem_resp;
      end
      SERVE_D: begin
        // Read and write are passed through unchanged, even when both are set.
        pmem_read        = dcache_pmem_read;
        pmem_write       = dcache_pmem_write;
        pmem_address     = dcache_pmem_address;
        pmem_wdata       = dcache_pmem_wdata;
        dcache_pmem_resp = pmem_resp;
      end
      default: ;
    endcase
  end

  assign icache_pmem_rdata = pmem_rdata;
  assign dcache_pmem_rdata = pmem_rdata;

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed bench for cache_arbiter: a round-robin instance plus a fixed-priority instance, both driven by the same inputs.
module tb_cache_arbiter;

  logic         clk;
  logic         rst_n;
  logic         icache_pmem_read;
  logic [15:0]  icache_pmem_address;
  logic         dcache_pmem_read;
  logic         dcache_pmem_write;
  logic [15:0]  dcache_pmem_address;
  logic [127:0] dcache_pmem_wdata;
  logic [127:0] pmem_rdata;
  logic         pmem_resp;

  logic [127:0] icache_pmem_rdata, dcache_pmem_rdata;
  logic         icache_pmem_resp, dcache_pmem_resp;
  logic         pmem_read, pmem_write;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata;

  logic [127:0] fx_icache_pmem_rdata, fx_dcache_pmem_rdata;
  logic         fx_icache_pmem_resp, fx_dcache_pmem_resp;
  logic         fx_pmem_read, fx_pmem_write;
  logic [15:0]  fx_pmem_address;
  logic [127:0] fx_pmem_wdata;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [127:0] LINE_A5 = {16{8'hA5}};
  localparam logic [127:0] LINE_3C = {16{8'h3C}};

  cache_arbiter #(.FAIR(1'b1)) u_dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .icache_pmem_read    (icache_pmem_read),
    .icache_pmem_address (icache_pmem_address),
    .icache_pmem_rdata   (icache_pmem_rdata),
    .icache_pmem_resp    (icache_pmem_resp),
    .dcache_pmem_read    (dcache_pmem_read),
    .dcache_pmem_write   (dcache_pmem_write),
    .dcache_pmem_address (dcache_pmem_address),
    .dcache_pmem_wdata   (dcache_pmem_wdata),
    .dcache_pmem_rdata   (dcache_pmem_rdata),
    .dcache_pmem_resp    (dcache_pmem_resp),
    .pmem_read           (pmem_read),
    .pmem_write          (pmem_write),
    .pmem_address        (pmem_address),
    .pmem_wdata          (pmem_wdata),
    .pmem_rdata          (pmem_rdata),
    .pmem_resp           (pmem_resp)
  );

  cache_arbiter #(.FAIR(1'b0)) u_fix (
    .clk                 (clk),
    .rst_n               (rst_n),
    .icache_pmem_read    (icache_pmem_read),
    .icache_pmem_address (icache_pmem_address),
    .icache_pmem_rdata   (fx_icache_pmem_rdata),
    .icache_pmem_resp    (fx_icache_pmem_resp),
    .dcache_pmem_read    (dcache_pmem_read),
    .dcache_pmem_write   (dcache_pmem_write),
    .dcache_pmem_address (dcache_pmem_address),
    .dcache_pmem_wdata   (dcache_pmem_wdata),
    .dcache_pmem_rdata   (fx_dcache_pmem_rdata),
    .dcache_pmem_resp    (fx_dcache_pmem_resp),
    .pmem_read           (fx_pmem_read),
    .pmem_write          (fx_pmem_write),
    .pmem_address        (fx_pmem_address),
    .pmem_wdata          (fx_pmem_wdata),
    .pmem_rdata          (pmem_rdata),
    .pmem_resp           (pmem_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    icache_pmem_read    = 1'b0;
    icache_pmem_address = 16'h0;
    dcache_pmem_read    = 1'b0;
    dcache_pmem_write   = 1'b0;
    dcache_pmem_address = 16'h0;
    dcache_pmem_wdata   = '0;
    pmem_rdata          = '0;
    pmem_resp           = 1'b0;
  endtask

  // Returns both instances to IDLE with last_served set to I.
  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    #1;
    step();
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    rst_n = 1'b1;
    clear_inputs();
    #2;

    // Reset state: every memory-side output and both response outputs are low.
    rst_n = 1'b0;
    #1;
    check("rst_pmem_read",  128'(pmem_read),        128'(0));
    check("rst_pmem_write", 128'(pmem_write),       128'(0));
    check("rst_pmem_addr",  128'(pmem_address),     128'(0));
    check("rst_i_resp",     128'(icache_pmem_resp), 128'(0));
    check("rst_d_resp",     128'(dcache_pmem_resp), 128'(0));
    step();
    rst_n = 1'b1;
    #1;

    // I read alone at 0x1230, with the response returned 3 cycles after the grant.
    icache_pmem_read    = 1'b1;
    icache_pmem_address = 16'h1230;
    #1;
    check("i_alone_latency", 128'(pmem_read), 128'(0));
    step();
    check("i_alone_read_c1", 128'(pmem_read),    128'(1));
    check("i_alone_addr",    128'(pmem_address), 128'(16'h1230));
    check("i_alone_write",   128'(pmem_write),   128'(0));
    check("i_alone_noresp",  128'(icache_pmem_resp), 128'(0));
    step();
    check("i_alone_read_c2", 128'(pmem_read), 128'(1));
    step();
    pmem_resp  = 1'b1;
    pmem_rdata = LINE_3C;
    #1;
    check("i_alone_read_c3", 128'(pmem_read),        128'(1));
    check("i_alone_i_resp",  128'(icache_pmem_resp), 128'(1));
    check("i_alone_d_resp",  128'(dcache_pmem_resp), 128'(0));
    check("i_rdata_fwd",     icache_pmem_rdata,      LINE_3C);
    check("d_rdata_fwd",     dcache_pmem_rdata,      LINE_3C);
    step();
    pmem_resp        = 1'b0;
    icache_pmem_read = 1'b0;
    #1;
    check("i_alone_done_read", 128'(pmem_read),        128'(0));
    check("i_alone_pulse",     128'(icache_pmem_resp), 128'(0));

    // Simultaneous I and D reads after reset: D is served first, then I after one IDLE cycle.
    do_reset();
    icache_pmem_read    = 1'b1;
    icache_pmem_address = 16'h1230;
    dcache_pmem_read    = 1'b1;
    dcache_pmem_address = 16'h4000;
    step();
    check("conf_first_addr", 128'(pmem_address), 128'(16'h4000));
    check("conf_first_read", 128'(pmem_read),    128'(1));
    pmem_resp = 1'b1;
    #1;
    check("conf_d_resp", 128'(dcache_pmem_resp), 128'(1));
    check("conf_i_hold", 128'(icache_pmem_resp), 128'(0));
    step();
    pmem_resp        = 1'b0;
    dcache_pmem_read = 1'b0;
    #1;
    check("conf_idle_gap", 128'(pmem_read), 128'(0));
    step();
    check("conf_second_addr", 128'(pmem_address), 128'(16'h1230));
    check("conf_second_read", 128'(pmem_read),    128'(1));
    pmem_resp = 1'b1;
    #1;
    check("conf_i_resp", 128'(icache_pmem_resp), 128'(1));
    step();
    clear_inputs();

    // D write-back, then D fill, with I pending: the order is D write, I read, D read.
    do_reset();
    icache_pmem_read    = 1'b1;
    icache_pmem_address = 16'h1230;
    dcache_pmem_write   = 1'b1;
    dcache_pmem_address = 16'h8000;
    dcache_pmem_wdata   = LINE_A5;
    step();
    check("wb_write",  128'(pmem_write),   128'(1));
    check("wb_addr",   128'(pmem_address), 128'(16'h8000));
    check("wb_wdata",  pmem_wdata,         LINE_A5);
    pmem_resp = 1'b1;
    #1;
    check("wb_d_resp", 128'(dcache_pmem_resp), 128'(1));
    step();
    pmem_resp         = 1'b0;
    dcache_pmem_write = 1'b0;
    dcache_pmem_read  = 1'b1;
    #1;
    check("wb_rearb_idle", 128'(pmem_read | pmem_write), 128'(0));
    step();
    check("wb_i_wins_addr",  128'(pmem_address), 128'(16'h1230));
    check("wb_i_wins_write", 128'(pmem_write),   128'(0));
    check("wb_i_wdata_zero", pmem_wdata,         128'(0));
    pmem_resp = 1'b1;
    #1;
    check("wb_i_resp", 128'(icache_pmem_resp), 128'(1));
    step();
    pmem_resp        = 1'b0;
    icache_pmem_read = 1'b0;
    step();
    check("wb_fill_read", 128'(pmem_read),    128'(1));
    check("wb_fill_addr", 128'(pmem_address), 128'(16'h8000));
    check("wb_fill_wdata_pass", pmem_wdata,   LINE_A5);
    step();
    clear_inputs();

    // Fixed priority (FAIR=0) with both sides requesting: D wins every arbitration.
    do_reset();
    icache_pmem_read    = 1'b1;
    icache_pmem_address = 16'h1230;
    dcache_pmem_read    = 1'b1;
    dcache_pmem_address = 16'h4000;
    step();
    check("fix_first_d", 128'(fx_pmem_address), 128'(16'h4000));
    pmem_resp = 1'b1;
    step();
    pmem_resp = 1'b0;
    step();
    check("fix_second_d",   128'(fx_pmem_address), 128'(16'h4000));
    check("fair_second_i",  128'(pmem_address),    128'(16'h1230));
    pmem_resp = 1'b1;
    #1;
    check("fix_d_resp",     128'(fx_dcache_pmem_resp), 128'(1));
    check("fix_i_no_resp",  128'(fx_icache_pmem_resp), 128'(0));
    step();
    pmem_resp        = 1'b0;
    dcache_pmem_read = 1'b0;
    step();
    check("fix_i_after_d", 128'(fx_pmem_address), 128'(16'h1230));
    check("fix_i_read",    128'(fx_pmem_read),    128'(1));
    step();
    clear_inputs();

    // Owner drops its request before any response: the FSM returns to IDLE.
    do_reset();
    dcache_pmem_read    = 1'b1;
    dcache_pmem_address = 16'h2220;
    step();
    check("abort_served", 128'(pmem_read), 128'(1));
    dcache_pmem_read = 1'b0;
    step();
    icache_pmem_read    = 1'b1;
    icache_pmem_address = 16'h1230;
    #1;
    check("abort_idle", 128'(pmem_read), 128'(0));
    step();
    check("abort_then_i", 128'(pmem_address), 128'(16'h1230));
    step();
    clear_inputs();

    // Reset asserted mid-write-back: the write drops without a clock edge and no response is delivered.
    do_reset();
    dcache_pmem_write   = 1'b1;
    dcache_pmem_address = 16'h8000;
    dcache_pmem_wdata   = LINE_A5;
    step();
    check("rst_mid_write_before", 128'(pmem_write), 128'(1));
    #1;
    rst_n     = 1'b0;
    pmem_resp = 1'b1;
    #1;
    check("rst_mid_write_async", 128'(pmem_write),       128'(0));
    check("rst_mid_no_resp",     128'(dcache_pmem_resp), 128'(0));
    check("rst_mid_wdata_zero",  pmem_wdata,             128'(0));
    step();
    clear_inputs();
    rst_n = 1'b1;
    #1;
    icache_pmem_read    = 1'b1;
    icache_pmem_address = 16'h1230;
    step();
    check("post_rst_i_addr", 128'(pmem_address), 128'(16'h1230));
    pmem_resp = 1'b1;
    #1;
    check("post_rst_i_resp", 128'(icache_pmem_resp), 128'(1));
    step();
    clear_inputs();

    // A stray pmem_resp in IDLE is ignored.
    do_reset();
    pmem_resp = 1'b1;
    #1;
    check("stray_i_resp", 128'(icache_pmem_resp), 128'(0));
    check("stray_d_resp", 128'(dcache_pmem_resp), 128'(0));
    step();
    pmem_resp        = 1'b0;
    icache_pmem_read = 1'b1;
    #1;
    check("stray_still_idle", 128'(pmem_read), 128'(0));
    step();
    check("stray_then_grant", 128'(pmem_read), 128'(1));
    clear_inputs();
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cache_arbiter.md
CACHE_ARBITER -- requirements
Module: cache_arbiter

Interface
REQ-001 Parameter FAIR, default 1: 1 = round-robin between requesters on conflict; 0 = fixed D-cache priority.
REQ-002 clk  in  1  system clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset; asynchronous, active-low.
REQ-004 icache_pmem_read  in  1  I-cache line-fill request, held until its resp.
REQ-005 icache_pmem_address  in  16 (lc3b_word)  I-cache line address.
REQ-006 icache_pmem_rdata  out  128 (lc3b_line)  line data to I-cache.
REQ-007 icache_pmem_resp  out  1  I-cache transaction complete.
REQ-008 dcache_pmem_read  in  1  D-cache line-fill request.
REQ-009 dcache_pmem_write  in  1  D-cache write-back request.
REQ-010 dcache_pmem_address  in  16  D-cache line address.
REQ-011 dcache_pmem_wdata  in  128  D-cache write-back line.
REQ-012 dcache_pmem_rdata  out  128  line data to D-cache.
REQ-013 dcache_pmem_resp  out  1  D-cache transaction complete.
REQ-014 pmem_read  out  1  physical memory read.
REQ-015 pmem_write  out  1  physical memory write.
REQ-016 pmem_address  out  16  physical memory address.
REQ-017 pmem_wdata  out  128  physical memory write data.
REQ-018 pmem_rdata  in  128  physical memory read data.
REQ-019 pmem_resp  in  1  physical memory done, one-cycle pulse.

Function
REQ-020 FSM states: IDLE, SERVE_I, SERVE_D; state is the only owner record.
REQ-021 IDLE: drives pmem_read, pmem_write, pmem_address, pmem_wdata all 0; both resp outputs 0.
REQ-022 IDLE, only I requesting -> SERVE_I; only D requesting (read or write) -> SERVE_D; none -> IDLE.
REQ-023 IDLE, both requesting: FAIR=0 -> SERVE_D; FAIR=1 -> grant the requester not recorded in last_served.
REQ-024 last_served register (1 bit, I/D) updates on every IDLE->SERVE_x transition to x.
REQ-025 Arbitration latency: exactly one cycle; memory request first appears the cycle after the request is seen in IDLE.
REQ-026 SERVE_I: pmem_read = icache_pmem_read, pmem_write = 0, pmem_address = icache_pmem_address, pmem_wdata = 0.
REQ-027 SERVE_D: pmem_read/pmem_write/pmem_address/pmem_wdata pass through the D-cache inputs combinationally.
REQ-028 pmem_rdata SHALL be forwarded to both icache_pmem_rdata and dcache_pmem_rdata at all times.
REQ-029 icache_pmem_resp = pmem_resp only in SERVE_I; dcache_pmem_resp = pmem_resp only in SERVE_D; otherwise 0.
REQ-030 SERVE_x with pmem_resp=1 -> IDLE next cycle, regardless of other requester.
REQ-031 SERVE_x with owner request dropped before pmem_resp -> IDLE next cycle (abort); last_served unchanged.
REQ-032 D-cache write-back followed by fill re-arbitrates through IDLE; under FAIR=1 a pending I request wins the fill slot.
REQ-033 dcache read and write asserted together is illegal; arbiter passes both unchanged, no checking.
REQ-034 pmem_resp while in IDLE is ignored; no resp forwarded, no state change.

Reset
REQ-035 rst_n low: state=IDLE, last_served=I immediately, without waiting for clk.
REQ-036 Reset mid-transaction abandons it; no resp delivered; all pmem outputs 0 while rst_n low.
REQ-037 First conflict after reset under FAIR=1 is granted to D.

Structure
REQ-038 lc3b_word and lc3b_line come from shared package lc3b_types; FSM enum stays local to the module.
REQ-039 No sub-module; single module with state register, next-state block, output mux block.

Verification
REQ-040 I read alone at addr 0x1230, pmem_resp after 3 cycles -> pmem_read high from cycle 1 to resp, icache_pmem_resp single pulse, dcache_pmem_resp 0.
REQ-041 I and D read same cycle, FAIR=1 after reset -> D served first (addr 0x4000), then I (0x1230) after one IDLE cycle.
REQ-042 D write-back 0x8000 data 0xA5..A5, then D fill 0x8000, I pending, FAIR=1 -> order: D write, I read, D read.
REQ-043 FAIR=0, both requesting continuously -> D granted every arbitration; I waits until D idle.
REQ-044 rst_n asserted mid SERVE_D -> pmem_write drops to 0 asynchronously, no resp; after release, new I request served normally.
REQ-045 Stray pmem_resp in IDLE -> both resp outputs remain 0, state stays IDLE.
